fft_dac: RTL

- Serial DAC writer (DAC8531-style, 24-bit SPI frame, MSB first) for the FFT signal path.
- It is the output-side counterpart of the ADC serial reader: it accepts 16-bit samples from the processing core over a valid/ready handshake and shifts each one out as a framed SYNC/SCL/DIN transfer.
- A one-entry holding buffer lets the core hand over the next sample while the current frame is still shifting.

---
 rtl/fft_dac_pkg.sv | 12 +
 rtl/fft_dac_if.sv | 15 +
 rtl/fft_scl_gen.sv | 31 +++
 rtl/fft_dac.sv | 83 ++++++++
 4 files changed

// File: rtl/fft_dac_pkg.sv
// fft_dac_pkg: shared constants, FSM encoding and frame packing for the serial DAC writer.
package fft_dac_pkg;
  localparam int FRAME_BITS   = 24;
  localparam int DATA_BITS    = 16;
  localparam int PD_BITS      = 2;
  localparam int SCL_HALF_DEF = 13;
  localparam int SYNC_GAP_DEF = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  function automatic logic [FRAME_BITS-1:0] frame_word(input logic [PD_BITS-1:0] pd, input logic [DATA_BITS-1:0] d);
    return {{(FRAME_BITS-PD_BITS-DATA_BITS){1'b0}}, pd, d};
  endfunction
endpackage

// File: rtl/fft_dac_if.sv
// fft_dac_if: sample handshake from the core plus the DAC serial pins and status.
interface fft_dac_if;
  import fft_dac_pkg::*;
  logic [DATA_BITS-1:0] iDATA;
  logic [PD_BITS-1:0]   iPD;
  logic                 iVALID;
  logic                 oREADY;
  logic                 oDAC_SYNC;
  logic                 oDAC_SCL;
  logic                 oDAC_DIN;
  logic                 oBUSY;
  logic                 oDONE;
  modport master (output iDATA, iPD, iVALID, input oREADY, oDAC_SYNC, oDAC_SCL, oDAC_DIN, oBUSY, oDONE);
  modport slave  (input iDATA, iPD, iVALID, output oREADY, oDAC_SYNC, oDAC_SCL, oDAC_DIN, oBUSY, oDONE);
endinterface

// File: rtl/fft_scl_gen.sv
// fft_scl_gen: half-period counter driving SCL with fall/rise strobes; idles high while disabled.
module fft_scl_gen #(
  parameter int HALF = 13
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic scl_o,
  output logic fall_o,
  output logic rise_o
);
  localparam int CW = $clog2(HALF);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          scl_q, scl_d, wrap;
  always_comb begin
    wrap   = en_i && cnt_q == CW'(HALF-1);
    cnt_d  = (!en_i || wrap) ? '0 : cnt_q + CW'(1);
    scl_d  = !en_i ? 1'b1 : wrap ? !scl_q : scl_q;
    fall_o = wrap && scl_q;
    rise_o = wrap && !scl_q;
    scl_o  = scl_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cnt_q <= '0;
      scl_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      scl_q <= scl_d;
    end
endmodule

// File: rtl/fft_dac.sv
// fft_dac: DAC8531-style 24-bit serial writer with a one-entry sample buffer.
// Data leaves MSB first; DIN changes on SCL rise so the DAC can sample it on the fall.
module fft_dac
  import fft_dac_pkg::*;
#(
  parameter int SCL_HALF = SCL_HALF_DEF,
  parameter int SYNC_GAP = SYNC_GAP_DEF
) (
  input logic        iCLK,
  input logic        iRESET,
  fft_dac_if.slave   dac
);
  localparam int GW = $clog2(SYNC_GAP + 1);
  localparam int BW = PD_BITS + DATA_BITS;
  state_t                state_q, state_d;
  logic                  full_q, full_d;
  logic [BW-1:0]         buf_q, buf_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [4:0]            bit_q, bit_d;
  logic                  last_q, last_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  done_q, done_d;
  logic                  scl, fall, rise, load, acc, fin;
  fft_scl_gen #(.HALF(SCL_HALF)) u_scl (
    .clk_i  (iCLK),
    .rst_ni (iRESET),
    .en_i   (state_q == SHIFT),
    .scl_o  (scl),
    .fall_o (fall),
    .rise_o (rise)
  );
  always_ff @(posedge iCLK or negedge iRESET)
    if (!iRESET) state_q <= IDLE;
    else         state_q <= state_d;
  always_comb begin
    load    = state_q == IDLE && full_q;
    fin     = state_q == SHIFT && rise && last_q;
    state_d = load ? SHIFT
            : fin ? GAP
            : (state_q == GAP && gap_q == GW'(SYNC_GAP-1)) ? IDLE
            : state_q;
  end
  always_comb begin
    dac.oDAC_SYNC = state_q != SHIFT;
    dac.oBUSY     = state_q != IDLE;
  end
  // last_q arms on the 24th fall so the following rise closes the frame
  always_comb begin
    acc    = dac.iVALID && !full_q;
    full_d = load ? 1'b0 : acc ? 1'b1 : full_q;
    buf_d  = acc ? {dac.iPD, dac.iDATA} : buf_q;
    sr_d   = load ? frame_word(buf_q[BW-1:DATA_BITS], buf_q[DATA_BITS-1:0])
           : fin ? '0
           : rise ? {sr_q[FRAME_BITS-2:0], 1'b0}
           : sr_q;
    bit_d  = load ? '0 : (rise && !last_q) ? bit_q + 5'd1 : bit_q;
    last_d = load ? 1'b0 : (fall && bit_q == 5'(FRAME_BITS-1)) ? 1'b1 : last_q;
    gap_d  = state_q == GAP ? gap_q + GW'(1) : '0;
    done_d = fin;
  end
  always_ff @(posedge iCLK or negedge iRESET)
    if (!iRESET) begin
      full_q <= 1'b0;
      buf_q  <= '0;
      sr_q   <= '0;
      bit_q  <= '0;
      last_q <= 1'b0;
      gap_q  <= '0;
      done_q <= 1'b0;
    end else begin
      full_q <= full_d;
      buf_q  <= buf_d;
      sr_q   <= sr_d;
      bit_q  <= bit_d;
      last_q <= last_d;
      gap_q  <= gap_d;
      done_q <= done_d;
    end
  assign dac.oREADY   = !full_q;
  assign dac.oDAC_SCL = scl;
  assign dac.oDAC_DIN = sr_q[FRAME_BITS-1];
  assign dac.oDONE    = done_q;
endmodule
